// File: rtl/calc_pkg.sv
// Shared constants and FSM encoding for the ALU result formatter and its neighbours.
package calc_pkg;

  localparam int RES_W = 32;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_DIG,
    SEND,
    CR,
    LF,
    FIN
  } fmt_state_e;

endpackage

// File: rtl/res_formatter_if.sv
// ALU-result-in / UART-byte-out bundle; master is the formatter side.
interface res_formatter_if;

  logic                       alu_done;
  logic [calc_pkg::RES_W-1:0] calc_res;
  logic                       tx_ready;
  logic [7:0]                 tx_data;
  logic                       tx_valid;
  logic                       busy;
  logic                       fmt_done;
  logic                       drop_err;

  modport master (
    input  alu_done, calc_res, tx_ready,
    output tx_data, tx_valid, busy, fmt_done, drop_err
  );

  modport slave (
    output alu_done, calc_res, tx_ready,
    input  tx_data, tx_valid, busy, fmt_done, drop_err
  );

endinterface

// File: rtl/nib2ascii.sv
// Combinational nibble to uppercase ASCII hex character.
module nib2ascii
  import calc_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] asc
);

  always_comb begin
    if (nib < 4'd10) asc = ASCII_0 + {4'h0, nib};
    else             asc = ASCII_A + {4'h0, nib} - 8'd10;
  end

endmodule

// File: rtl/res_formatter.sv
// Latches an ALU result and streams it as ASCII hex (MSB nibble first) plus optional CR LF.
// Optional build macro RES_FORMATTER_ZERO_SUPPRESS_EN skips leading zero nibbles.
module res_formatter
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int EOL_EN     = 1
) (
  input  logic            clk,
  input  logic            rst,
  res_formatter_if.master bus
);

  localparam int              CNT_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  fmt_state_e       state_q, state_d;
  logic [RES_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  logic [CNT_W-1:0] sel_cnt;
  logic [3:0]       nib;
  logic [7:0]       nib_asc;

  // In SEND the nibble on deck is the one after the byte currently transferring.
  always_comb begin
    sel_cnt = (state_q == SEND) ? cnt_q - CNT_ONE : cnt_q;
    nib     = res_q[{sel_cnt, 2'b00} +: 4];
  end

  nib2ascii u_nib2ascii (
    .nib (nib),
    .asc (nib_asc)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = drop_q | (bus.alu_done && (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (bus.alu_done) begin
          res_d   = bus.calc_res;
          cnt_d   = CNT_TOP;
          busy_d  = 1'b1;
          state_d = LOAD_DIG;
        end
      end
      LOAD_DIG: begin
`ifdef RES_FORMATTER_ZERO_SUPPRESS_EN
        if ((nib == 4'h0) && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          data_d  = nib_asc;
          vld_d   = 1'b1;
          state_d = SEND;
        end
`else
        data_d  = nib_asc;
        vld_d   = 1'b1;
        state_d = SEND;
`endif
      end
      SEND: begin
        if (bus.tx_ready) begin
          if (cnt_q != '0) begin
            cnt_d  = cnt_q - CNT_ONE;
            data_d = nib_asc;
          end else if (EOL_EN != 0) begin
            data_d  = ASCII_CR;
            state_d = CR;
          end else begin
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end
        end
      end
      CR: begin
        if (bus.tx_ready) begin
          data_d  = ASCII_LF;
          state_d = LF;
        end
      end
      LF: begin
        if (bus.tx_ready) begin
          vld_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      data_q  <= 8'h00;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.tx_data  = data_q;
  assign bus.tx_valid = vld_q;
  assign bus.busy     = busy_q;
  assign bus.fmt_done = done_q;
  assign bus.drop_err = drop_q;

endmodule

// File: tb/tb_res_formatter.sv
// Bench for res_formatter: 8-digit/EOL instance (a) and 4-digit/no-EOL instance (b).
module tb_res_formatter;

`ifdef RES_FORMATTER_ZERO_SUPPRESS_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  res_formatter_if ia();
  res_formatter_if ib();

  res_formatter #(.NUM_DIGITS(8), .EOL_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
  res_formatter #(.NUM_DIGITS(4), .EOL_EN(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic string vis(input string s);
    string o = "";
    for (int k = 0; k < s.len(); k++) begin
      if (s.getc(k) == 8'h0D)      o = {o, "\\r"};
      else if (s.getc(k) == 8'h0A) o = {o, "\\n"};
      else                         o = $sformatf("%s%c", o, s.getc(k));
    end
    return o;
  endfunction

  task automatic chks(input string nm, input string act, input string exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", nm, vis(act), vis(exp));
  endtask

  // Reference: hex text of the low nd nibbles, optional zero suppression, optional CR LF.
  function automatic string ref_str(input logic [31:0] r, input int nd, input bit eol, input bit zs);
    string hx = "0123456789ABCDEF";
    string s = "";
    bit lead = zs;
    for (int d = nd - 1; d >= 0; d--) begin
      int n = int'((r >> (4 * d)) & 32'hF);
      if (lead && n == 0 && d > 0) continue;
      lead = 1'b0;
      s = {s, hx.substr(n, n)};
    end
    if (eol) s = {s, "\015\012"};
    return s;
  endfunction

  // Byte-stream monitor and tx_ready driver, all on the falling edge.
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int   cyc = 0;
  int   stall[2], wcnt[2], first_vld[2], first_x[2], last_x[2], fmt_cnt[2], fmt_cyc[2];
  logic pv[2], rdy[2];
  logic [7:0] pd[2];
  logic [1:0] vn, fdn;
  logic [1:0][7:0] dn;

  assign vn = {ib.tx_valid, ia.tx_valid};
  assign fdn = {ib.fmt_done, ia.fmt_done};
  assign dn[0] = ia.tx_data;
  assign dn[1] = ib.tx_data;
  assign ia.tx_ready = rdy[0];
  assign ib.tx_ready = rdy[1];

  initial begin
    for (int i = 0; i < 2; i++) begin
      stall[i] = 0; wcnt[i] = 0; pv[i] = 1'b0; pd[i] = 8'h00; rdy[i] = 1'b0;
      first_vld[i] = -1; first_x[i] = -1; last_x[i] = -1; fmt_cnt[i] = 0; fmt_cyc[i] = -1;
    end
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (pv[i] && rdy[i]) begin
          if (i == 0) got_a.push_back(pd[i]); else got_b.push_back(pd[i]);
          if (first_x[i] < 0) first_x[i] = cyc - 1;
          last_x[i] = cyc - 1;
          wcnt[i] = 0;
        end else if (pv[i] && !rdy[i]) begin
          chk($sformatf("stall hold dut%0d", i), {vn[i], dn[i]}, {1'b1, pd[i]});
        end
        if (fdn[i]) begin
          fmt_cnt[i]++;
          fmt_cyc[i] = cyc;
        end
        if (vn[i] && first_vld[i] < 0) first_vld[i] = cyc;
        if (vn[i]) begin
          if (wcnt[i] >= stall[i]) rdy[i] = 1'b1;
          else begin rdy[i] = 1'b0; wcnt[i]++; end
        end else begin
          rdy[i] = (stall[i] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        pv[i] = vn[i];
        pd[i] = dn[i];
      end
    end
  end

  int t0;

  task automatic clear_stats(input int i, input int st);
    if (i == 0) got_a.delete(); else got_b.delete();
    stall[i] = st; wcnt[i] = 0;
    first_vld[i] = -1; first_x[i] = -1; last_x[i] = -1; fmt_cnt[i] = 0; fmt_cyc[i] = -1;
  endtask

  task automatic start_frame(input int i, input logic [31:0] r, input int st);
    @(posedge clk); #2;
    clear_stats(i, st);
    if (i == 0) begin ia.alu_done = 1'b1; ia.calc_res = r; end
    else        begin ib.alu_done = 1'b1; ib.calc_res = r; end
    t0 = cyc;
    @(posedge clk); #2;
    if (i == 0) begin ia.alu_done = 1'b0; ia.calc_res = $urandom; end
    else        begin ib.alu_done = 1'b0; ib.calc_res = $urandom; end
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (fmt_cnt[i] == 0 && n < 500) begin @(posedge clk); #2; n++; end
    if (fmt_cnt[i] == 0) chk($sformatf("timeout dut%0d", i), 0, 1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic wait_bytes(input int i, input int nb);
    int n = 0;
    while (((i == 0) ? got_a.size() : got_b.size()) < nb && n < 500) begin @(posedge clk); #2; n++; end
    if (n >= 500) chk($sformatf("byte wait timeout dut%0d", i), 0, 1);
  endtask

  task automatic check_frame(input int i, input string nm, input string exp);
    string s = "";
    if (i == 0) foreach (got_a[k]) s = $sformatf("%s%c", s, got_a[k]);
    else        foreach (got_b[k]) s = $sformatf("%s%c", s, got_b[k]);
    chks({nm, " bytes"}, s, exp);
    chk({nm, " fmt_done pulses"}, fmt_cnt[i], 1);
    chk({nm, " fmt_done after last xfer"}, fmt_cyc[i], last_x[i] + 1);
    chk({nm, " busy idle"}, (i == 0) ? ia.busy : ib.busy, 0);
  endtask

  typedef struct {
    logic [31:0] res;
    int          st;
    string       exp_full;
    string       exp_zs;
  } vec_t;

  vec_t tbl[6];
  string ex;
  int    snap;

  initial begin
    tbl[0] = '{32'h1234ABCD, 0, "1234ABCD", "1234ABCD"};
    tbl[1] = '{32'hDEADBEEF, 5, "DEADBEEF", "DEADBEEF"};
    tbl[2] = '{32'h00000000, 0, "00000000", "0"};
    tbl[3] = '{32'h000001A3, 2, "000001A3", "1A3"};
    tbl[4] = '{32'hFFFFFFFF, 1, "FFFFFFFF", "FFFFFFFF"};
    tbl[5] = '{32'h90000000, 0, "90000000", "90000000"};

    rst = 1'b1;
    ia.alu_done = 1'b0; ia.calc_res = '0;
    ib.alu_done = 1'b0; ib.calc_res = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset tx_data", ia.tx_data, 8'h00);
    chk("reset tx_valid", ia.tx_valid, 0);
    chk("reset busy", ia.busy, 0);
    chk("reset fmt_done", ia.fmt_done, 0);
    chk("reset drop_err", ia.drop_err, 0);
    chk("reset b tx_valid", ib.tx_valid, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    foreach (tbl[v]) begin
      start_frame(0, tbl[v].res, tbl[v].st);
      wait_done(0);
      ex = ZS ? tbl[v].exp_zs : tbl[v].exp_full;
      check_frame(0, $sformatf("tbl%0d", v), {ex, "\015\012"});
      if (v == 0) begin
        chk("first valid latency", first_vld[0] - t0, 3);
        chk("no bubbles", last_x[0] - first_x[0], 9);
      end
      chk($sformatf("tbl%0d drop_err", v), ia.drop_err, 0);
    end

    start_frame(1, 32'h123400FF, 0);
    wait_done(1);
    check_frame(1, "4dig noeol", ZS ? "FF" : "00FF");

    for (int r = 0; r < 16; r++) begin
      int d = r % 2;
      logic [31:0] v = $urandom >> ($urandom_range(0, 7) * 4);
      int st = $urandom_range(0, 3);
      start_frame(d, v, st);
      wait_done(d);
      check_frame(d, $sformatf("rand%0d dut%0d %h", r, d, v),
                  ref_str(v, (d == 0) ? 8 : 4, d == 0, ZS));
    end

    // Second request mid-frame is dropped; the sticky flag survives the next frame.
    start_frame(0, 32'h00000007, 1);
    wait_bytes(0, ZS ? 1 : 2);
    @(posedge clk); #2;
    ia.alu_done = 1'b1; ia.calc_res = 32'h5;
    @(posedge clk); #2;
    ia.alu_done = 1'b0;
    wait_done(0);
    check_frame(0, "drop frame", ref_str(32'h7, 8, 1'b1, ZS));
    chk("drop_err set", ia.drop_err, 1);
    start_frame(0, 32'h000000A5, 0);
    wait_done(0);
    check_frame(0, "after drop", ref_str(32'hA5, 8, 1'b1, ZS));
    chk("drop_err sticky", ia.drop_err, 1);

    // Reset mid-frame aborts immediately.
    start_frame(0, 32'h12345678, 0);
    wait_bytes(0, 3);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async rst tx_valid", ia.tx_valid, 0);
    chk("async rst busy", ia.busy, 0);
    chk("async rst drop_err", ia.drop_err, 0);
    @(negedge clk); #1;
    snap = got_a.size();
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("no bytes after abort", got_a.size(), snap);
    chk("no fmt_done after abort", fmt_cnt[0], 0);
    start_frame(0, 32'hFFFFFFFF, 0);
    wait_done(0);
    check_frame(0, "post reset", "FFFFFFFF\015\012");
    chk("post reset drop_err", ia.drop_err, 0);

    // alu_done held three cycles: first accepted, the rest flagged.
    @(posedge clk); #2;
    clear_stats(0, 0);
    ia.alu_done = 1'b1; ia.calc_res = 32'h00C0FFEE;
    repeat (3) @(posedge clk);
    #2;
    ia.alu_done = 1'b0; ia.calc_res = 32'h11111111;
    wait_done(0);
    check_frame(0, "held alu_done", ref_str(32'h00C0FFEE, 8, 1'b1, ZS));
    chk("held drop_err", ia.drop_err, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global timeout");
    $fatal(1);
  end

endmodule

// File: doc/res_formatter.md
Name: res_formatter

Overview:
- Downstream neighbour of the ALU. Captures the 32-bit result when `alu_done` is high and serialises it as uppercase ASCII hex characters, followed by CR LF.
- Output is a valid/ready byte stream into the UART transmitter.
- Sits between the ALU and `uart_tx`, and frees the ALU result bus as soon as the result is latched.

Parameters:
- NUM_DIGITS, 8, number of hex nibbles emitted, MSB nibble first; legal range 1..8; nibbles above NUM_DIGITS-1 are never emitted.
- EOL_EN, 1, 1 = append 0x0D 0x0A after the digits; 0 = digits only.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_done  in  1  result-valid strobe from ALU; level-sampled every clk
- calc_res  in  32  ALU result; sampled only in the cycle alu_done is accepted
- tx_ready  in  1  UART transmitter can accept a byte this cycle
- tx_data  out  8  ASCII byte to transmitter
- tx_valid  out  1  tx_data is valid; transfer occurs when tx_valid & tx_ready
- busy  out  1  high from the accept cycle until the last byte transfers
- fmt_done  out  1  one-cycle pulse in the cycle after the final byte transfers
- drop_err  out  1  sticky: an alu_done arrived while busy; cleared only by rst

Behaviour:

Clock and reset:
- One clock, `clk`. Reset `rst` is asynchronous and active-high.
- While rst=1, every register is reset immediately:
  - tx_data=0x00, tx_valid=0, busy=0, fmt_done=0, drop_err=0
  - FSM=IDLE, digit counter=0, result register=0
- Reset asserted mid-frame aborts the frame. No further bytes are emitted after release.

State machine:
- IDLE -> LOAD_DIG:
  - Condition: alu_done=1 in IDLE.
  - calc_res latched into res_q; digit counter = NUM_DIGITS-1; busy=1 at the next edge.
- LOAD_DIG -> SEND:
  - tx_data = ascii(res_q[4*cnt+3 -: 4]); tx_valid=1.
  - First tx_valid therefore appears 2 cycles after the alu_done edge.
- SEND:
  - Holds tx_data and tx_valid stable while tx_ready=0.
  - On transfer with cnt>0: cnt decrements, and at the next edge tx_data holds the next nibble with tx_valid still 1. No bubble between digits.
  - On transfer of the last digit: go to CR if EOL_EN=1, else FIN.
- CR: tx_data=0x0D, tx_valid=1; transfer -> LF.
- LF: tx_data=0x0A, tx_valid=1; transfer -> FIN.
- FIN:
  - tx_valid=0, busy=0, fmt_done=1 for exactly one cycle; -> IDLE.
  - alu_done in FIN is counted as a drop.

Encoding and flow-control rules:
- Nibble encoding: 0..9 -> 0x30..0x39; A..F -> 0x41..0x46.
- tx_valid is never deasserted before its byte transfers, and tx_data never changes while tx_valid=1 and tx_ready=0.
- tx_ready while tx_valid=0 is ignored.

Boundary and error conditions:
- alu_done while busy or in FIN: request ignored, res_q unchanged, drop_err set to 1 (sticky).
- alu_done held high for several cycles in IDLE: only the first cycle is accepted. Later cycles while busy set drop_err.
- Upstream must pulse alu_done for a single cycle.

Optional Feature:
- Macro: RES_FORMATTER_ZERO_SUPPRESS_EN.
- When defined:
  - Leading '0' nibbles are skipped without consuming tx cycles; skipping is done in LOAD_DIG at one nibble per clock.
  - The least-significant nibble is always emitted, so result 0 sends "0".
  - Example: 0x0000_01A3 sends "1A3".
- When undefined: exactly NUM_DIGITS digits are always sent.
- fmt_done, busy and drop_err semantics are identical in both builds.

Decomposition:
- Shared package (`calc_pkg`) holds:
  - FSM state encoding: IDLE, LOAD_DIG, SEND, CR, LF, FIN.
  - ASCII constants: ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_0=8'h30, ASCII_A=8'h41.
  - Result width constant RES_W=32.
- One natural sub-module: `nib2ascii`, purely combinational, 4-bit in, 8-bit out. It is reused by the parser's echo path.

Test Plan:
- alu_done pulse, calc_res=0x1234_ABCD, tx_ready tied 1 -> bytes "1234ABCD\r\n" (0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44,0x0D,0x0A) on 10 consecutive cycles. First byte valid 2 cycles after alu_done. fmt_done pulses once.
- calc_res=0xDEAD_BEEF, tx_ready low for 5 cycles on every byte -> tx_data and tx_valid stable during each stall. Sequence "DEADBEEF\r\n" with no byte lost or duplicated.
- Second alu_done (calc_res=0x5) during the 3rd digit of frame 0x0000_0007 -> output "00000007\r\n" only. drop_err=1 and stays 1 until rst.
- rst asserted during the 4th digit -> tx_valid=0, busy=0 immediately, no further bytes. A new alu_done with 0xFFFF_FFFF then sends "FFFFFFFF\r\n".
- With RES_FORMATTER_ZERO_SUPPRESS_EN: calc_res=0 -> "0\r\n"; calc_res=0x0000_01A3 -> "1A3\r\n".
- NUM_DIGITS=4, EOL_EN=0, calc_res=0x1234_00FF -> "00FF" only. fmt_done follows the last transfer by 1 cycle.
